aibnd_avmm_sercore: RTL and testbench

//  Parametrised AVMM sideband serialiser/deserialiser feeding the aibnd_buffx1_top TX/RX buffers.
//  TX: buffers DWIDTH-bit words in a FIFO and frames each one as header + payload beats.

---
 rtl/aibnd_avmm_sercore.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_aibnd_avmm_sercore.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aibnd_avmm_sercore.sv
// AVMM sideband serialiser/deserialiser: word FIFO -> header+payload(+parity) beats on NLANE lanes, and back.
// Latency: header on idat from the 2nd edge after word acceptance; rx_valid one cycle after the last received beat.
// Backpressure: tx_ready (registered !full) throttles writers; RX has none, rx_data is held until the next rx_valid.
// Optional parity beat and RX check are built when AIBND_AVMM_PARITY_EN is defined.

module aibnd_avmm_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    // Generic synchronous FIFO with a registered write-ready (low out of reset).
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    logic          push;
    logic          pop;

    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_rdy & rd_vld;
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];

    // Occupancy after this cycle's push/pop, used to register the ready flag.
    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + (AW+1)'(1);
        end else if (!push && pop) begin
            cnt_nxt = cnt - (AW+1)'(1);
        end
    end

    // Pointers, occupancy and ready; ready rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            wr_rdy <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt    <= cnt_nxt;
            wr_rdy <= (cnt_nxt != FULL_CNT);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module aibnd_avmm_sercore #(
    parameter int NLANE      = 2,
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              avmm_clk,
    input  logic              avmm_sync_rstb,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [NLANE-1:0]  avmm_idat0,
    output logic [NLANE-1:0]  avmm_idat1,
    input  logic [NLANE-1:0]  avmm_odat0,
    input  logic [NLANE-1:0]  avmm_odat1,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_perr,
    output logic              tx_busy
);
    localparam int BW    = 2 * NLANE;
    localparam int BEATS = DWIDTH / BW;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
    localparam logic [BW-1:0] HDR_BEAT = BW'(1);
`ifdef AIBND_AVMM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    generate
        if (NLANE < 1 || NLANE > 8) begin : g_bad_nlane
            $error("NLANE must be in 1..8");
        end
        if (DWIDTH % (2 * NLANE) != 0) begin : g_bad_dwidth
            $error("DWIDTH must be a multiple of 2*NLANE");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA, TX_PAR} tx_state_t;
    typedef enum logic [1:0] {RX_HUNT, RX_COLLECT, RX_CHECK} rx_state_t;

    tx_state_t         tx_state, tx_state_nxt;
    rx_state_t         rx_state, rx_state_nxt;
    logic              fifo_vld;
    logic              fifo_pop;
    logic [DWIDTH-1:0] fifo_dat;
    logic [DWIDTH-1:0] tx_word;
    logic [CW-1:0]     tx_cnt;
    logic [BW-1:0]     tx_beat_nxt;
    logic [NLANE-1:0]  idat0_nxt;
    logic [NLANE-1:0]  idat1_nxt;
    logic [BW-1:0]     rx_beat;
    logic [CW-1:0]     rx_cnt;
    logic [DWIDTH-1:0] rx_shift;
    logic [DWIDTH-1:0] rx_word_nxt;
    logic [DWIDTH-1:0] rx_load_dat;
    logic              rx_load;

    aibnd_avmm_fifo #(
        .W     (DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk    (avmm_clk),
        .rst_n  (avmm_sync_rstb),
        .wr_vld (tx_valid),
        .wr_dat (tx_data),
        .wr_rdy (tx_ready),
        .rd_vld (fifo_vld),
        .rd_rdy (fifo_pop),
        .rd_dat (fifo_dat)
    );

    assign tx_busy = (tx_state != TX_IDLE) | fifo_vld;

    // TX next state and the beat to register onto the pins this edge.
    always_comb begin
        tx_state_nxt = tx_state;
        fifo_pop     = 1'b0;
        tx_beat_nxt  = '0;
        case (tx_state)
            TX_IDLE: begin
                if (fifo_vld) begin
                    tx_state_nxt = TX_HDR;
                    fifo_pop     = 1'b1;
                end
            end
            TX_HDR: begin
                tx_beat_nxt  = HDR_BEAT;
                tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                tx_beat_nxt = tx_word[tx_cnt*BW +: BW];
                if (tx_cnt == LAST_CNT) begin
                    if (PAR_EN) begin
                        tx_state_nxt = TX_PAR;
                    end else if (fifo_vld) begin
                        tx_state_nxt = TX_HDR;
                        fifo_pop     = 1'b1;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            TX_PAR: begin
                tx_beat_nxt = BW'(^tx_word);
                if (fifo_vld) begin
                    tx_state_nxt = TX_HDR;
                    fifo_pop     = 1'b1;
                end else begin
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Split a beat into per-lane even/odd bits.
    always_comb begin
        idat0_nxt = '0;
        idat1_nxt = '0;
        for (int i = 0; i < NLANE; i++) begin
            idat0_nxt[i] = tx_beat_nxt[2*i];
            idat1_nxt[i] = tx_beat_nxt[2*i+1];
        end
    end

    // TX state, word holding register, beat counter and registered pins.
    always_ff @(posedge avmm_clk or negedge avmm_sync_rstb) begin
        if (!avmm_sync_rstb) begin
            tx_state   <= TX_IDLE;
            tx_word    <= '0;
            tx_cnt     <= '0;
            avmm_idat0 <= '0;
            avmm_idat1 <= '0;
        end else begin
            tx_state   <= tx_state_nxt;
            avmm_idat0 <= idat0_nxt;
            avmm_idat1 <= idat1_nxt;
            if (fifo_pop) tx_word <= fifo_dat;
            if (tx_state == TX_HDR) begin
                tx_cnt <= '0;
            end else if (tx_state == TX_DATA) begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    // Merge the received lanes back into one beat.
    always_comb begin
        rx_beat = '0;
        for (int i = 0; i < NLANE; i++) begin
            rx_beat[2*i]   = avmm_odat0[i];
            rx_beat[2*i+1] = avmm_odat1[i];
        end
    end

    // RX next state: hunt for the header, collect beats, then deliver the word.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_word_nxt  = rx_shift;
        rx_load      = 1'b0;
        rx_load_dat  = rx_shift;
        case (rx_state)
            RX_HUNT: begin
                if (rx_beat == HDR_BEAT) rx_state_nxt = RX_COLLECT;
            end
            RX_COLLECT: begin
                rx_word_nxt[rx_cnt*BW +: BW] = rx_beat;
                if (rx_cnt == LAST_CNT) begin
                    if (PAR_EN) begin
                        rx_state_nxt = RX_CHECK;
                    end else begin
                        rx_load      = 1'b1;
                        rx_load_dat  = rx_word_nxt;
                        rx_state_nxt = RX_HUNT;
                    end
                end
            end
            RX_CHECK: begin
                rx_load      = 1'b1;
                rx_state_nxt = RX_HUNT;
            end
            default: rx_state_nxt = RX_HUNT;
        endcase
    end

    // RX state, assembly register and the delivered word / valid pulse.
    always_ff @(posedge avmm_clk or negedge avmm_sync_rstb) begin
        if (!avmm_sync_rstb) begin
            rx_state <= RX_HUNT;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_valid <= rx_load;
            if (rx_load) rx_data <= rx_load_dat;
            if (rx_state == RX_COLLECT) begin
                rx_shift <= rx_word_nxt;
                rx_cnt   <= rx_cnt + CW'(1);
            end else begin
                rx_cnt   <= '0;
            end
        end
    end

`ifdef AIBND_AVMM_PARITY_EN
    // Even-parity check of the beat after the payload, pulsed alongside rx_valid.
    always_ff @(posedge avmm_clk or negedge avmm_sync_rstb) begin
        if (!avmm_sync_rstb) begin
            rx_perr <= 1'b0;
        end else begin
            rx_perr <= (rx_state == RX_CHECK) && (rx_beat[0] != ^rx_shift);
        end
    end
`else
    assign rx_perr = 1'b0;
`endif
endmodule

// File: tb/tb_aibnd_avmm_sercore.sv
// Loopback bench for aibnd_avmm_sercore: scoreboard queues filled by the drivers, drained by pin/RX monitors.
// Covers reset values, latency, back-to-back framing, noise rejection, reset mid-frame and a 1-lane instance.
// Parity expectations follow AIBND_AVMM_PARITY_EN when it is defined for the build.

module tb_aibnd_avmm_sercore;
    localparam int BEATS = 4;
`ifdef AIBND_AVMM_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Instance A: 2 lanes, 16-bit words; odat from loopback or manual drive.
    logic [15:0] tx_data_a = '0;
    logic        tx_valid_a = 1'b0;
    logic        tx_ready_a, rx_valid_a, rx_perr_a, tx_busy_a;
    logic [1:0]  idat0_a, idat1_a, odat0_a, odat1_a;
    logic [1:0]  man0_a = '0, man1_a = '0;
    logic        loop_a = 1'b1;
    logic [15:0] rx_data_a;
    assign odat0_a = loop_a ? idat0_a : man0_a;
    assign odat1_a = loop_a ? idat1_a : man1_a;

    aibnd_avmm_sercore #(.NLANE(2), .DWIDTH(16), .FIFO_DEPTH(4)) u_dut_a (
        .avmm_clk(clk), .avmm_sync_rstb(rst_n),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .avmm_idat0(idat0_a), .avmm_idat1(idat1_a),
        .avmm_odat0(odat0_a), .avmm_odat1(odat1_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_perr(rx_perr_a), .tx_busy(tx_busy_a)
    );

    // Instance B: 1 lane, 8-bit words, plain loopback.
    logic [7:0] tx_data_b = '0;
    logic       tx_valid_b = 1'b0;
    logic       tx_ready_b, rx_valid_b, rx_perr_b, tx_busy_b;
    logic [0:0] idat0_b, idat1_b;
    logic [7:0] rx_data_b;

    aibnd_avmm_sercore #(.NLANE(1), .DWIDTH(8), .FIFO_DEPTH(2)) u_dut_b (
        .avmm_clk(clk), .avmm_sync_rstb(rst_n),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .avmm_idat0(idat0_b), .avmm_idat1(idat1_b),
        .avmm_odat0(idat0_b), .avmm_odat1(idat1_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_perr(rx_perr_b), .tx_busy(tx_busy_b)
    );

    logic [16:0] rxq_a[$];
    logic [15:0] txq_a[$];
    logic [8:0]  rxq_b[$];
    int hdr_cyc_a = -1, rxv_cyc_a = -1, rxv_cnt_a = 0;
    int frame_end_cyc = -10, b2b_frames = 0;
    bit b2b_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] info);
        n_tests++;
        n_fail++;
        $display("FAIL %s: observed 0x%0h where none was expected (cycle %0d)", name, info, cyc);
    endtask

    // Pins of A as one beat: bit 2i = idat0[i], bit 2i+1 = idat1[i].
    function automatic logic [3:0] pins_a();
        return {idat1_a[1], idat0_a[1], idat1_a[0], idat0_a[0]};
    endfunction

    task automatic set_beat_a(input logic [3:0] b);
        man0_a = {b[2], b[0]};
        man1_a = {b[3], b[1]};
    endtask

    // RX scoreboards: every rx_valid must match the next expected word (and parity flag).
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid_a) begin
                rxv_cyc_a = cyc;
                rxv_cnt_a++;
                if (rxq_a.size() == 0) fail_now("rx_a_unexpected", 32'(rx_data_a));
                else begin
                    logic [16:0] e;
                    e = rxq_a.pop_front();
                    check("rx_a_data", 32'(rx_data_a), 32'(e[15:0]));
                    check("rx_a_perr", 32'(rx_perr_a), 32'(e[16]));
                end
            end else if (rx_perr_a) fail_now("rx_a_perr_stray", 32'(rx_perr_a));
            if (rx_valid_b) begin
                if (rxq_b.size() == 0) fail_now("rx_b_unexpected", 32'(rx_data_b));
                else begin
                    logic [8:0] e;
                    e = rxq_b.pop_front();
                    check("rx_b_data", 32'(rx_data_b), 32'(e[7:0]));
                    check("rx_b_perr", 32'(rx_perr_b), 32'(e[8]));
                end
            end
        end
    end

    // TX pin monitor for A: find a header, rebuild the word from lane bits, check parity beat.
    int          pin_k = -1;
    logic [15:0] pw;
    always @(negedge clk) begin
        if (!rst_n) pin_k = -1;
        else if (pin_k < 0) begin
            if (pins_a() == 4'b0001) begin
                hdr_cyc_a = cyc;
                if (b2b_chk && b2b_frames > 0) check("b2b_no_gap", 32'(cyc), 32'(frame_end_cyc + 1));
                pin_k = 0;
                pw = '0;
            end
        end else begin
            if (pin_k < BEATS) pw[4*pin_k +: 4] = pins_a();
            else check("tx_a_par_beat", 32'(pins_a()), {31'd0, ^pw});
            pin_k++;
            if (pin_k == BEATS + PB) begin
                if (txq_a.size() == 0) fail_now("tx_a_unexpected", 32'(pw));
                else check("tx_a_word", 32'(pw), 32'(txq_a.pop_front()));
                frame_end_cyc = cyc;
                if (b2b_chk) b2b_frames++;
                pin_k = -1;
            end
        end
    end

    // Present a word at a negedge; junk data while not ready; returns the accepting edge's cycle.
    task automatic send_a(input logic [15:0] w, input bit exp_en, output int acc);
        int budget = 0;
        tx_valid_a = 1'b1;
        while (!tx_ready_a && budget < 500) begin
            tx_data_a = 16'($urandom);
            @(negedge clk);
            budget++;
        end
        acc = -1;
        if (!tx_ready_a) fail_now("send_a_timeout", 32'(w));
        else begin
            tx_data_a = w;
            acc = cyc + 1;
            if (exp_en) begin
                txq_a.push_back(w);
                rxq_a.push_back({1'b0, w});
            end
            @(negedge clk);
        end
    endtask

    task automatic send_b(input logic [7:0] w, output int acc);
        int budget = 0;
        tx_valid_b = 1'b1;
        while (!tx_ready_b && budget < 500) begin
            tx_data_b = 8'($urandom);
            @(negedge clk);
            budget++;
        end
        acc = -1;
        if (!tx_ready_b) fail_now("send_b_timeout", 32'(w));
        else begin
            tx_data_b = w;
            acc = cyc + 1;
            rxq_b.push_back({1'b0, w});
            @(negedge clk);
        end
        tx_valid_b = 1'b0;
    endtask

    // Hand-built frame on A's odat; bad=1 flips the parity bit.
    task automatic drive_frame_a(input logic [15:0] w, input bit bad);
        rxq_a.push_back({bad && (PB != 0), w});
        set_beat_a(4'b0001);
        @(negedge clk);
        for (int k = 0; k < BEATS; k++) begin
            set_beat_a(w[4*k +: 4]);
            @(negedge clk);
        end
        if (PB != 0) begin
            set_beat_a({3'b000, (^w) ^ bad});
            @(negedge clk);
        end
        set_beat_a(4'b0000);
    endtask

    task automatic drain();
        int t = 0;
        while ((rxq_a.size() + txq_a.size() + rxq_b.size()) != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if ((rxq_a.size() + txq_a.size() + rxq_b.size()) != 0)
            fail_now("drain_timeout", 32'(rxq_a.size() + txq_a.size() + rxq_b.size()));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int acc;
        int base;
        logic [15:0] w;
        logic [7:0]  wb;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_tx_ready_a", 32'(tx_ready_a), 0);
        check("rst_idat_a", 32'(pins_a()), 0);
        check("rst_rx_valid_a", 32'(rx_valid_a), 0);
        check("rst_rx_data_a", 32'(rx_data_a), 0);
        check("rst_rx_perr_a", 32'(rx_perr_a), 0);
        check("rst_tx_busy_a", 32'(tx_busy_a), 0);
        check("rst_tx_ready_b", 32'(tx_ready_b), 0);
        check("rst_rx_data_b", 32'(rx_data_b), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_tx_ready_a", 32'(tx_ready_a), 1);
        check("rel_tx_ready_b", 32'(tx_ready_b), 1);

        // Single word with latency checks.
        send_a(16'hA5C3, 1'b1, acc);
        tx_valid_a = 1'b0;
        check("busy_after_accept", 32'(tx_busy_a), 1);
        drain();
        check("a5c3_hdr_latency", 32'(hdr_cyc_a), 32'(acc + 2));
        check("a5c3_rxv_latency", 32'(rxv_cyc_a), 32'(acc + 2 + BEATS + PB + 1));
        check("busy_after_drain", 32'(tx_busy_a), 0);

        // Back-to-back: five words fill the FIFO; frames must be contiguous.
        b2b_chk = 1'b1;
        b2b_frames = 0;
        for (int i = 0; i < 5; i++) send_a(16'($urandom), 1'b1, acc);
        tx_valid_a = 1'b0;
        check("b2b_fifo_full", 32'(tx_ready_a), 0);
        drain();
        check("b2b_frames", 32'(b2b_frames), 5);
        b2b_chk = 1'b0;

        // Noise without a header, then a good hand-built frame.
        loop_a = 1'b0;
        base = rxv_cnt_a;
        for (int i = 0; i < 6; i++) begin
            set_beat_a((i % 2 == 0) ? 4'hC : 4'h8);
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            set_beat_a(4'($urandom) & 4'hE);
            @(negedge clk);
        end
        set_beat_a(4'h0);
        repeat (3) @(negedge clk);
        check("noise_no_rx_valid", 32'(rxv_cnt_a), 32'(base));
        drive_frame_a(16'h3C5A, 1'b0);
        drain();
        drive_frame_a(16'h0001, 1'b1);
        drain();
        drive_frame_a(16'h0001, 1'b0);
        drain();
        loop_a = 1'b1;

        // Reset during beat 2: pins clear at once, no rx_valid, ready back one edge after release.
        w = 16'($urandom) | 16'h0F00;
        base = rxv_cnt_a;
        send_a(w, 1'b0, acc);
        tx_valid_a = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("mid_beat2_on_pins", 32'(pins_a()), 32'(w[11:8]));
        rst_n = 1'b0;
        #1;
        check("mid_rst_idat_zero", 32'(pins_a()), 0);
        check("mid_rst_tx_ready", 32'(tx_ready_a), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_tx_ready", 32'(tx_ready_a), 1);
        check("mid_rel_tx_busy", 32'(tx_busy_a), 0);
        repeat (12) @(negedge clk);
        check("mid_no_rx_valid", 32'(rxv_cnt_a), 32'(base));
        send_a(16'($urandom), 1'b1, acc);
        tx_valid_a = 1'b0;
        drain();

        // Randomised traffic with random gaps.
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(0, 4);
            if (gap != 0) begin
                tx_valid_a = 1'b0;
                repeat (gap) @(negedge clk);
            end
            send_a(16'($urandom), 1'b1, acc);
        end
        tx_valid_a = 1'b0;
        drain();

        // 1-lane instance: 8'h96 beat by beat, then random words.
        wb = 8'h96;
        send_b(wb, acc);
        while (cyc < acc + 2) @(negedge clk);
        check("b_header", 32'({idat1_b, idat0_b}), 1);
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            check("b_beat", 32'({idat1_b, idat0_b}), 32'(2'(wb >> (2 * k))));
        end
        drain();
        for (int i = 0; i < 10; i++) send_b(8'($urandom), acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
